// File: rtl/u41_eval.sv
// u41_eval: recomputes the 16-entry function table realised by a 10-pin u41 wiring.
// Optional illegal-code checking via `U41_EVAL_CHECK_EN (err tied to 0 when undefined).
module u41_eval #(
    parameter logic [1023:0] GATE_LUT = {512{2'b10}}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  pin,
    input  logic [2:0]  wiring,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] func,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  vec_q;
    logic [15:0] func_q;
    logic [2:0]  wiring_q [10];
    logic [9:0]  addr;
    logic        any_illegal;

    // Each pin resolves its wiring code against the current input vector.
    always_comb begin
        addr        = '0;
        any_illegal = 1'b0;
        for (int unsigned p = 0; p < 10; p++) begin
            unique case (wiring_q[p])
                3'd0, 3'd1, 3'd2, 3'd3: addr[p] = vec_q[wiring_q[p][1:0]];
                3'd5:                   addr[p] = 1'b1;
                default:                addr[p] = 1'b0;
            endcase
            if (wiring_q[p][2:1] == 2'b11) begin
                any_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                wr_ready = 1'b1;
                if (start) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                busy = 1'b1;
                if (vec_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= 4'hF;
            func_q <= '0;
            for (int unsigned p = 0; p < 10; p++) begin
                wiring_q[p] <= 3'd4;
            end
        end else begin
            if (state_q == S_IDLE && wr_valid && pin <= 4'd9) begin
                wiring_q[pin] <= wiring;
            end
            if (state_q == S_IDLE && start) begin
                vec_q <= 4'hF;
            end
            // Vectors run 15 down to 0, so vector i lands in func[i] after 16 shifts.
            if (state_q == S_EVAL) begin
                func_q <= {func_q[14:0], GATE_LUT[addr]};
                vec_q  <= vec_q - 4'd1;
            end
        end
    end

    assign func = func_q;

`ifdef U41_EVAL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            err_q <= 1'b0;
        end else if (state_q == S_EVAL && any_illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_illegal;
    assign unused_illegal = any_illegal;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_u41_eval.sv
// Directed bench for u41_eval: default LUT (output = pin 0) and an AND-of-pins-0/1 LUT.
module tb_u41_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  pin = '0;
    logic [2:0]  wiring = '0;
    logic        start = 1'b0;
    logic        wr_ready, busy, done, err;
    logic [15:0] func;
    logic        a_wr_ready, a_busy, a_done, a_err;
    logic [15:0] a_func;

    int checks   = 0;
    int failures = 0;
    int done_cyc, busy_cyc, n_done;
    logic exp_err;

    always #5 clk = ~clk;

    u41_eval dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .pin(pin), .wiring(wiring), .start(start), .busy(busy),
        .done(done), .func(func), .err(err)
    );

    u41_eval #(.GATE_LUT({256{4'b1000}})) dut_and (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
        .pin(pin), .wiring(wiring), .start(start), .busy(a_busy),
        .done(a_done), .func(a_func), .err(a_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_write(input logic [3:0] p, input logic [2:0] w);
        @(negedge clk);
        wr_valid = 1'b1;
        pin      = p;
        wiring   = w;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run_eval(output int dc, output int bc);
        dc = 0;
        bc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                dc = i;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
`ifdef U41_EVAL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_func", 32'(func), 32'h0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);

        run_eval(done_cyc, busy_cyc);
        check("default_done_cycle", 32'(done_cyc), 32'd17);
        check("default_busy_cycles", 32'(busy_cyc), 32'd16);
        check("default_func", 32'(func), 32'h0000);
        check("idle_after_done", 32'(wr_ready), 32'd1);

        do_write(4'd0, 3'd0);
        do_write(4'd1, 3'd1);
        run_eval(done_cyc, busy_cyc);
        check("var0_func", 32'(func), 32'hAAAA);
        check("and_v0v1_func", 32'(a_func), 32'h8888);

        do_write(4'd0, 3'd3);
        run_eval(done_cyc, busy_cyc);
        check("var3_func", 32'(func), 32'hFF00);
        check("and_v3v1_func", 32'(a_func), 32'hCC00);

        do_write(4'd0, 3'd5);
        run_eval(done_cyc, busy_cyc);
        check("const1_func", 32'(func), 32'hFFFF);
        check("and_c1v1_func", 32'(a_func), 32'hCCCC);

        do_write(4'd1, 3'd4);
        run_eval(done_cyc, busy_cyc);
        check("and_pin1_const0", 32'(a_func), 32'h0000);

        // Out-of-range pin must not alias onto any stored pin.
        do_write(4'd12, 3'd0);
        do_write(4'd10, 3'd1);
        run_eval(done_cyc, busy_cyc);
        check("pin12_dropped", 32'(func), 32'hFFFF);
        check("pin12_dropped_and", 32'(a_func), 32'h0000);

        // Write and start during EVAL are both ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wr_valid = 1'b1;
        pin      = 4'd0;
        wiring   = 3'd0;
        start    = 1'b1;
        check("busy_wr_ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        start    = 1'b0;
        n_done   = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("single_done", 32'(n_done), 32'd1);
        check("busy_write_dropped", 32'(func), 32'hFFFF);

        // Write and start in the same IDLE cycle: evaluation sees the new code.
        @(negedge clk);
        wr_valid = 1'b1;
        pin      = 4'd0;
        wiring   = 3'd0;
        start    = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        start    = 1'b0;
        done_cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                done_cyc = i;
                break;
            end
            @(negedge clk);
        end
        check("wr_start_done_cycle", 32'(done_cyc), 32'd17);
        check("wr_start_func", 32'(func), 32'hAAAA);
        @(negedge clk);

        // Reset in EVAL cycle 8.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_func", 32'(func), 32'h0000);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        run_eval(done_cyc, busy_cyc);
        check("midrst_wiring_reset", 32'(func), 32'h0000);
        check("midrst_rerun_done_cycle", 32'(done_cyc), 32'd17);

        // Illegal codes read as 0.
        do_write(4'd0, 3'd5);
        run_eval(done_cyc, busy_cyc);
        check("pre_illegal_func", 32'(func), 32'hFFFF);
        do_write(4'd0, 3'd6);
        run_eval(done_cyc, busy_cyc);
        check("illegal6_func", 32'(func), 32'h0000);
        check("illegal6_err", 32'(err), 32'(exp_err));
        do_write(4'd0, 3'd0);
        check("err_held_until_start", 32'(err), 32'(exp_err));
        run_eval(done_cyc, busy_cyc);
        check("legal_rerun_func", 32'(func), 32'hAAAA);
        check("legal_rerun_err", 32'(err), 32'd0);
        do_write(4'd0, 3'd7);
        run_eval(done_cyc, busy_cyc);
        check("illegal7_func", 32'(func), 32'h0000);
        check("illegal7_err", 32'(err), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
